// File: rtl/iterative_shifter_pkg.sv
// Shared types for the multi-cycle shifter: operation encoding and FSM states.
package shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'd0,
      SHIFT_SRL = 2'd1,
      SHIFT_SRA = 2'd2,
      SHIFT_ROR = 2'd3
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bits needed to hold a per-cycle step count in the range 0..step.
   function automatic int step_width(input int step);
      return $clog2(step + 1);
   endfunction

endpackage

// File: rtl/iterative_shifter_step.sv
// One partial shift of up to STEP bits. Purely combinational.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic [WIDTH-1:0]                 value,
   input  shift_op_t                        op,
   input  logic                             fill,
   input  logic [step_width(STEP)-1:0]      step,
   output logic [WIDTH-1:0]                 shifted
);

   localparam int RW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] fill_mask;
   logic [RW-1:0]    back;

   // Shift the work value by 'step' bits; the fill bit only matters for SRA
   // and comes from the operand MSB captured at accept time.
   always_comb begin
      fill_mask = ~({WIDTH{1'b1}} >> step);
      back      = RW'(WIDTH) - RW'(step);
      shifted   = value;
      case (op)
         SHIFT_SLL: shifted = value << step;
         SHIFT_SRL: shifted = value >> step;
         SHIFT_SRA: shifted = (value >> step) | (fill ? fill_mask : '0);
         SHIFT_ROR: shifted = (value >> step) | (value << back);
         default:   shifted = value;
      endcase
   end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter with start/done handshake. Shifts at most
// STEP bits per clock; busy is high while the shift is in progress.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_SHIFT | applying min(remaining, STEP) per cycle to the work value
//   ST_DONE  | one-cycle done pulse; result valid; start accepted here too
module iterative_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data,
   input  logic [AMT_W-1:0] shift_amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int SW = step_width(STEP);

   state_t           state;
   shift_op_t        op_q;
   logic             fill_q;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] remaining;

   logic [SW-1:0]    step;
   logic [AMT_W-1:0] remaining_next;
   logic [WIDTH-1:0] shifted;

   // Step size for this cycle: whatever is left, capped at STEP.
   always_comb begin
      if (32'(remaining) < 32'(STEP))
         step = SW'(remaining);
      else
         step = SW'(STEP);
      remaining_next = remaining - AMT_W'(step);
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .value   (work),
      .op      (op_q),
      .fill    (fill_q),
      .step    (step),
      .shifted (shifted)
   );

   // Control FSM with registered busy/done/result; reset discards any
   // in-flight operation without producing a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_q      <= SHIFT_SLL;
         fill_q    <= 1'b0;
         work      <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  work      <= data;
                  op_q      <= shift_op_t'(op);
                  fill_q    <= data[WIDTH-1];
                  remaining <= shift_amount;
                  if (shift_amount != '0) begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                  end else begin
                     state  <= ST_DONE;
                     done   <= 1'b1;
                     result <= data;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               work      <= shifted;
               remaining <= remaining_next;
               if (remaining_next == '0) begin
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= shifted;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: stimulus pushes expected result,
// done cycle and busy length; a negedge monitor pops and compares on done.
module tb_iterative_shifter;

   localparam int WIDTH = 32;
   localparam int STEP  = 4;
   localparam int AMT_W = $clog2(WIDTH);

   localparam logic [1:0] OP_SLL = 2'd0;
   localparam logic [1:0] OP_SRL = 2'd1;
   localparam logic [1:0] OP_SRA = 2'd2;
   localparam logic [1:0] OP_ROR = 2'd3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       op = 2'd0;
   logic [WIDTH-1:0] data = '0;
   logic [AMT_W-1:0] shift_amount = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .data         (data),
      .shift_amount (shift_amount),
      .busy         (busy),
      .done         (done),
      .result       (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] res;
      int               cyc;
      int               nbusy;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   bcnt  = 0;
   logic [WIDTH-1:0] prev_res = '0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] o, input logic [WIDTH-1:0] d,
                                                  input int a);
      case (o)
         OP_SLL:  return d << a;
         OP_SRL:  return d >> a;
         OP_SRA:  return $signed(d) >>> a;
         default: return (a == 0) ? d : ((d >> a) | (d << (WIDTH - a)));
      endcase
   endfunction

   // Monitor: pops the scoreboard on every done; also checks result stays put
   // while busy.
   always @(negedge clk) begin
      if (reset) begin
         bcnt = 0;
      end else begin
         if (busy) begin
            bcnt++;
            check("result_held_while_busy", 64'(result), 64'(prev_res));
         end
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'(0));
            end else begin
               exp_t e;
               e = q.pop_front();
               check("result", 64'(result), 64'(e.res));
               check("done_cycle", 64'(cyc), 64'(e.cyc));
               check("busy_cycles", 64'(bcnt), 64'(e.nbusy));
            end
            bcnt = 0;
         end
      end
      prev_res = result;
   end

   // Caller is positioned #1 after a rising edge; that cycle is the start cycle.
   task automatic drive(input logic [1:0] o, input logic [WIDTH-1:0] d, input int a,
                        input logic [WIDTH-1:0] exp_res);
      exp_t e;
      int   nb;
      nb = (a + STEP - 1) / STEP;
      e.res   = exp_res;
      e.cyc   = cyc + nb + 1;
      e.nbusy = nb;
      q.push_back(e);
      start        = 1'b1;
      op           = o;
      data         = d;
      shift_amount = AMT_W'(a);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         check("wait_idle_timeout", 64'(q.size()), 64'(0));
         q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_done_visible();
      int n;
      n = 0;
      while (!done && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) check("wait_done_timeout", 64'(done), 64'(1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]       ro;
      logic [WIDTH-1:0] rd;
      int               ra;

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_result", 64'(result), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      drive(OP_SRA, 32'h8000_0000, 4, 32'hF800_0000);  wait_idle();
      drive(OP_SRA, 32'h8000_0000, 31, 32'hFFFF_FFFF); wait_idle();
      drive(OP_SRL, 32'h8000_0000, 31, 32'h0000_0001); wait_idle();
      drive(OP_SLL, 32'h0000_0001, 31, 32'h8000_0000); wait_idle();
      drive(OP_ROR, 32'h1234_5678, 8, 32'h7812_3456);  wait_idle();
      drive(OP_SRA, 32'h7FFF_FFF0, 3, 32'h0FFF_FFFE);  wait_idle();
      drive(OP_ROR, 32'h0000_0001, 1, 32'h8000_0000);  wait_idle();
      drive(OP_SLL, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);  wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("result_hold_idle", 64'(result), 64'h0000_0000_DEAD_BEEF);

      // Start pulsed during SHIFT must be ignored.
      drive(OP_SRL, 32'hFFFF_0000, 16, 32'h0000_FFFF);
      start = 1'b1; op = OP_SLL; data = 32'h1234_5678; shift_amount = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      data = 32'hFFFF_FFFF; op = OP_ROR;
      wait_idle();

      // Back-to-back: second start issued in the DONE cycle.
      drive(OP_SLL, 32'h0000_00F0, 5, 32'h0000_1E00);
      wait_done_visible();
      drive(OP_SRA, 32'hF000_0000, 9, 32'hFFF8_0000);
      wait_idle();

      // Asynchronous reset two cycles into a 31-bit shift.
      drive(OP_SLL, 32'h0000_0001, 31, 32'h8000_0000);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("midshift_reset_busy", 64'(busy), 64'(0));
      check("midshift_reset_done", 64'(done), 64'(0));
      check("midshift_reset_result", 64'(result), 64'(0));
      q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      drive(OP_SLL, 32'h0000_0001, 1, 32'h0000_0002);
      wait_idle();

      for (int i = 0; i < 300; i++) begin
         ro = 2'($urandom_range(0, 3));
         rd = $urandom;
         ra = $urandom_range(0, WIDTH - 1);
         drive(ro, rd, ra, ref_shift(ro, rd, ra));
         if (i % 3 == 0) begin
            wait_done_visible();
         end else begin
            wait_idle();
         end
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
